// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, status-flag bit positions and
// small opcode helpers used by the status path.
package alu_pkg;

    // Opcodes the adder/subtractor actually executes; all others are
    // non-arithmetic and never report carry or overflow.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    // Bit positions of the flags inside a packed status bus.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    localparam int FLAG_W = 4;

    typedef logic [FLAG_W-1:0] flags_t;

    // True when the opcode goes through the adder and so has meaningful
    // carry/overflow information.
    function automatic logic is_arith(input logic [2:0] sel);
        return (sel == OP_ADD) || (sel == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_ovf_detect.sv
// Width-generic signed overflow detector. Purely combinational so that
// multi-lane variants can drop one per lane in front of their own registers.
module alu_ovf_detect
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [2:0]   sel,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic [W-1:0] res_in,
    output logic         ovf
);

    localparam int MSB = W - 1;

    logic sign_a;
    logic sign_b;
    logic sign_r;

    assign sign_a = op_a[MSB];
    assign sign_b = op_b[MSB];
    assign sign_r = res_in[MSB];

    // Only the sign bits decide overflow; the rest of each word is carried
    // through the port so every lane shares the same interface.
    logic unused_lsbs;
    assign unused_lsbs = ^{op_a[MSB-1:0], op_b[MSB-1:0], res_in[MSB-1:0]};

    // Add overflows when like-signed operands give an opposite-signed
    // result; sub overflows when unlike-signed operands give a result whose
    // sign differs from the minuend. Anything else cannot overflow.
    always_comb begin
        ovf = 1'b0;
        case (sel)
            OP_ADD:  ovf = (sign_a == sign_b) && (sign_r != sign_a);
            OP_SUB:  ovf = (sign_a != sign_b) && (sign_r != sign_a);
            default: ovf = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_status_unit.sv
// Registered status-flag unit placed after the adder/subtractor. Produces
// N/Z/C/V, an optionally saturated result, a sticky overflow flag and a
// saturating overflow event counter, all with one cycle of latency.
module alu_status_unit
    import alu_pkg::*;
#(
    parameter int W      = 8,
    parameter int CNT_W  = 4,
    parameter int SAT_EN = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [2:0]       sel,
    input  logic [W-1:0]     op_a,
    input  logic [W-1:0]     op_b,
    input  logic [W-1:0]     res_in,
    input  logic             carry_in,
    input  logic             clear,
    output logic             out_valid,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic [W-1:0]     res_out,
    output logic             sticky_v,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int               MSB     = W - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Clamp to the signed extreme on the side the true result ran off to.
    // The true result always has the sign of operand A when overflow
    // occurs, so A's sign picks max-positive versus min-negative.
    function automatic logic signed [W-1:0] saturate(
        input logic signed [W-1:0] raw,
        input logic                ovf,
        input logic                sign_a
    );
        logic signed [W-1:0] max_pos;
        logic signed [W-1:0] min_neg;
        max_pos = {1'b0, {(W-1){1'b1}}};
        min_neg = {1'b1, {(W-1){1'b0}}};
        if ((SAT_EN != 0) && ovf) begin
            return sign_a ? min_neg : max_pos;
        end
        return raw;
    endfunction

    // Increment that sticks at the top of the range instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    endfunction

    // Combinational overflow for the current operation.
    logic ovf;

    alu_ovf_detect #(
        .W (W)
    ) u_ovf_detect (
        .sel    (sel),
        .op_a   (op_a),
        .op_b   (op_b),
        .res_in (res_in),
        .ovf    (ovf)
    );

    logic signed [W-1:0] res_sat;
    logic                carry_eff;
    logic                ovf_event;

    assign res_sat   = saturate(res_in, ovf, op_a[MSB]);
    assign carry_eff = is_arith(sel) & carry_in;
    assign ovf_event = in_valid & ovf;

    // Registered state and its next-state values.
    logic             valid_q,  valid_d;
    flags_t           flags_q,  flags_d;
    logic [W-1:0]     res_q,    res_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    // Next-state for the result/flag pipeline: capture on a valid input,
    // otherwise hold the last captured values.
    always_comb begin
        valid_d = in_valid;
        flags_d = flags_q;
        res_d   = res_q;
        if (in_valid) begin
            res_d           = res_sat;
            flags_d[FLAG_N] = res_sat[MSB];
            flags_d[FLAG_Z] = (res_sat == '0);
            flags_d[FLAG_C] = carry_eff;
            flags_d[FLAG_V] = ovf;
        end
    end

    // Next-state for the accumulating overflow status. A clear that lands
    // on the same edge as an overflow restarts the history with that event
    // rather than discarding it.
    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (clear) begin
            sticky_d = ovf_event;
            cnt_d    = ovf_event ? CNT_ONE : '0;
        end else if (ovf_event) begin
            sticky_d = 1'b1;
            cnt_d    = sat_inc(cnt_q);
        end
    end

    // All state registers; reset wins over clear and in_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            flags_q  <= '0;
            res_q    <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            flags_q  <= flags_d;
            res_q    <= res_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign flag_n    = flags_q[FLAG_N];
    assign flag_z    = flags_q[FLAG_Z];
    assign flag_c    = flags_q[FLAG_C];
    assign flag_v    = flags_q[FLAG_V];
    assign res_out   = res_q;
    assign sticky_v  = sticky_q;
    assign ovf_count = cnt_q;

endmodule
